sprom_stream_reader: RTL and testbench

//  Sequencer that sits directly upstream of SPROM. It drives SPROM's read address and consumes SPROM's read data.
//  It turns a (base, length) command into a valid/ready output stream of ROM words, e.g. for coefficient or wavetable playback.
//  It hides SPROM's fixed read latency (1 cycle, or 2 with OUTPUT_REG) and tolerates downstream backpressure without losing words.

---
 rtl/sprom_stream_pkg.sv | 24 ++
 rtl/sprom_stream_fifo.sv | 75 +++++++
 rtl/sprom_stream_reader.sv | 179 +++++++++++++++++
 tb/tb_sprom_stream_reader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprom_stream_pkg.sv
// Shared definitions for the SPROM stream reader.
//   state_t      : sequencer states
//   ad_width()   : ROM address width derived from ROM depth
//   read_latency(): SPROM read latency from its OUTPUT_REG setting
package sprom_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One cycle for the registered array read, plus one more with OUTPUT_REG.
  localparam int BASE_LATENCY = 1;

  function automatic int ad_width(input int depth);
    return (depth >= 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int read_latency(input int output_reg);
    return (output_reg != 0) ? BASE_LATENCY + 1 : BASE_LATENCY;
  endfunction

endpackage

// File: rtl/sprom_stream_fifo.sv
// Synchronous output buffer for the stream reader (no fall-through).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request and word
//   pop, rdata    : read request and head word
//   flush         : synchronous clear of all entries
//   full, empty   : occupancy flags
//   count         : number of stored words
module sprom_stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end else begin
        count <= count;
      end
    end
  end

endmodule

// File: rtl/sprom_stream_reader.sv
// Turns a (base, length) command into a valid/ready stream of SPROM words,
// hiding the SPROM read latency and absorbing downstream backpressure.
// Ports:
//   CLK_I, RST_I                 : clock, synchronous active-high reset
//   START_I, BASE_ADDR_I,
//   LENGTH_I, LOOP_I, ABORT_I    : command interface
//   ROM_RADDR_O, ROM_RDATA_I     : SPROM read port (SPROM lives in the parent)
//   M_DATA_O, M_VALID_O,
//   M_READY_I, M_LAST_O          : output stream
//   BUSY_O                       : high whenever not idle
module sprom_stream_reader
  import sprom_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int OUTPUT_REG = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int AD_WIDTH  = ad_width(DEPTH)
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  START_I,
  input  logic [AD_WIDTH-1:0]   BASE_ADDR_I,
  input  logic [AD_WIDTH:0]     LENGTH_I,
  input  logic                  LOOP_I,
  input  logic                  ABORT_I,
  output logic [AD_WIDTH-1:0]   ROM_RADDR_O,
  input  logic [DATA_WIDTH-1:0] ROM_RDATA_I,
  output logic [DATA_WIDTH-1:0] M_DATA_O,
  output logic                  M_VALID_O,
  input  logic                  M_READY_I,
  output logic                  M_LAST_O,
  output logic                  BUSY_O
);

  localparam int L  = read_latency(OUTPUT_REG);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(L + 1) + 1;
  localparam logic [AD_WIDTH:0] DEPTH_LEN = (AD_WIDTH + 1)'(DEPTH);

  if (FIFO_DEPTH < L + 1) begin : g_fifo_depth_check
    $error("FIFO_DEPTH must be at least the SPROM read latency plus one");
  end

  state_t              state;
  logic [AD_WIDTH-1:0] addr;
  logic [AD_WIDTH-1:0] base;
  logic [AD_WIDTH:0]   remaining;
  logic [AD_WIDTH:0]   length;
  logic                loop_mode;
  logic                busy;
  logic [L-1:0]        pipe_valid;
  logic [L-1:0]        pipe_last;
  logic [IW-1:0]       inflight;
  logic [AD_WIDTH:0]   len_clamped;
  logic                issue;
  logic                last_issue;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [DATA_WIDTH:0] fifo_head;

  assign len_clamped = (LENGTH_I > DEPTH_LEN) ? DEPTH_LEN : LENGTH_I;
  assign last_issue  = (remaining == (AD_WIDTH + 1)'(1));

  // Number of reads whose data has not yet reached the buffer.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) begin
      inflight = inflight + IW'(pipe_valid[i]);
    end
  end

  // A read is issued only when the buffer is guaranteed a slot for its data.
  assign issue = (state == RUN) && !ABORT_I && !fifo_full &&
                 ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

  // The address register is the SPROM address; SPROM samples it on an issue cycle.
  assign ROM_RADDR_O = addr;
  assign BUSY_O      = busy;

  // Sequencer: command latch, address/remaining counters and state.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state     <= IDLE;
      addr      <= '0;
      base      <= '0;
      remaining <= '0;
      length    <= '0;
      loop_mode <= 1'b0;
      busy      <= 1'b0;
    end else if (ABORT_I) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START_I && (LENGTH_I != '0)) begin
            base      <= BASE_ADDR_I;
            addr      <= BASE_ADDR_I;
            length    <= len_clamped;
            remaining <= len_clamped;
            loop_mode <= LOOP_I;
            state     <= RUN;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            if (last_issue) begin
              if (loop_mode) begin
                addr      <= base;
                remaining <= length;
              end else begin
                // Address stays on the final word so the ROM port shows exactly the swept range.
                state <= DRAIN;
              end
            end else begin
              addr      <= addr + AD_WIDTH'(1);
              remaining <= remaining - (AD_WIDTH + 1)'(1);
            end
          end
        end
        DRAIN: begin
          if ((inflight == '0) && fifo_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // In-flight tags travel alongside each read so that the tag at the last stage
  // lines up with the matching SPROM data.
  always_ff @(posedge CLK_I) begin
    if (RST_I || ABORT_I) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_last[0]  <= issue && last_issue;
      for (int i = 1; i < L; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  assign fifo_push = pipe_valid[L-1];
  assign fifo_pop  = !fifo_empty && M_READY_I;

  sprom_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_I),
    .rst   (RST_I),
    .push  (fifo_push),
    .wdata ({ROM_RDATA_I, pipe_last[L-1]}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .flush (ABORT_I),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign M_VALID_O = !fifo_empty;
  assign M_DATA_O  = fifo_head[DATA_WIDTH:1];
  assign M_LAST_O  = fifo_head[0];

endmodule

// File: tb/tb_sprom_stream_reader.sv
// Bench for sprom_stream_reader: two instances (OUTPUT_REG=0 and 1) share one
// stimulus, each attached to its own SPROM model holding word[a] = 8'hFF - a.
module tb_sprom_stream_reader;

  localparam logic [7:0] S1_DATA [4] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
  localparam logic [7:0] S2_DATA [4] = '{8'h01, 8'h00, 8'hFF, 8'hFE};
  localparam logic [7:0] S2_ADDR [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  localparam logic [7:0] S5_DATA [3] = '{8'hDF, 8'hDE, 8'hDD};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, loop_i, abort, ready;
  logic [7:0] base;
  logic [8:0] len;
  logic [7:0] raddr [2];
  logic [7:0] mdata [2];
  logic       mvalid [2];
  logic       mlast [2];
  logic       busy [2];
  logic [7:0] rd0, rd1a, rd1;
  logic [7:0] rom [256];

  int n_vec = 0;
  int n_fail = 0;
  int ready_mode = 0;
  int rp = 0;
  int cyc = 0;
  logic rec_on = 1'b0;

  // Reference model state per instance.
  logic       active [2];
  logic [7:0] mb [2];
  int         ml [2];
  logic       mloop [2];
  int         idx [2];
  int         lat [2];
  logic       lat_pend [2];
  logic       held [2];
  logic [7:0] hd [2];
  logic       hl [2];
  logic [8:0] logw [2][300];
  int         logc [2][300];
  int         logn [2];
  logic [7:0] rseq [2][8];
  int         rn [2];

  sprom_stream_reader #(.DATA_WIDTH(8), .DEPTH(256), .OUTPUT_REG(0), .FIFO_DEPTH(4)) u_dut0 (
    .CLK_I(clk), .RST_I(rst), .START_I(start), .BASE_ADDR_I(base), .LENGTH_I(len),
    .LOOP_I(loop_i), .ABORT_I(abort), .ROM_RADDR_O(raddr[0]), .ROM_RDATA_I(rd0),
    .M_DATA_O(mdata[0]), .M_VALID_O(mvalid[0]), .M_READY_I(ready), .M_LAST_O(mlast[0]),
    .BUSY_O(busy[0]));

  sprom_stream_reader #(.DATA_WIDTH(8), .DEPTH(256), .OUTPUT_REG(1), .FIFO_DEPTH(4)) u_dut1 (
    .CLK_I(clk), .RST_I(rst), .START_I(start), .BASE_ADDR_I(base), .LENGTH_I(len),
    .LOOP_I(loop_i), .ABORT_I(abort), .ROM_RADDR_O(raddr[1]), .ROM_RDATA_I(rd1),
    .M_DATA_O(mdata[1]), .M_VALID_O(mvalid[1]), .M_READY_I(ready), .M_LAST_O(mlast[1]),
    .BUSY_O(busy[1]));

  // SPROM models: one registered read stage, plus an output register for the second instance.
  always @(posedge clk) begin
    rd0  <= rom[raddr[0]];
    rd1a <= rom[raddr[1]];
    rd1  <= rd1a;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [7:0] ea, ed;
    logic       el;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (held[d])
        chk("hold_stable", 32'({mvalid[d], mlast[d], mdata[d]}), 32'({1'b1, hl[d], hd[d]}));
      if (mvalid[d] === 1'b1)
        chk("valid_only_when_words_owed", 32'(active[d]), 1);
      if (mvalid[d] === 1'b1 && ready && active[d]) begin
        ea = 8'(int'(mb[d]) + idx[d]);
        ed = 8'hFF - ea;
        el = (idx[d] == ml[d] - 1);
        chk("stream_word", 32'({mlast[d], mdata[d]}), 32'({el, ed}));
        if (logn[d] < 300) begin
          logw[d][logn[d]] = {mlast[d], mdata[d]};
          logc[d][logn[d]] = cyc;
          logn[d]++;
        end
        idx[d]++;
        if (idx[d] == ml[d]) begin
          idx[d] = 0;
          if (!mloop[d]) active[d] = 1'b0;
        end
      end
      held[d] = (mvalid[d] === 1'b1) && !ready && !abort && !rst;
      hd[d] = mdata[d];
      hl[d] = mlast[d];
      if (rec_on && busy[d] && rn[d] < 8 && (rn[d] == 0 || rseq[d][rn[d]-1] != raddr[d])) begin
        rseq[d][rn[d]] = raddr[d];
        rn[d]++;
      end
      if (lat_pend[d]) begin
        lat[d]++;
        if (mvalid[d] === 1'b1 || lat[d] > 20) begin
          chk("first_valid_latency", lat[d], d + 2);
          lat_pend[d] = 1'b0;
        end
      end
      if (rst || abort) begin
        active[d]   = 1'b0;
        lat_pend[d] = 1'b0;
      end else if (start && !active[d] && len != 9'd0) begin
        active[d]   = 1'b1;
        mb[d]       = base;
        ml[d]       = (len > 9'd256) ? 256 : int'(len);
        mloop[d]    = loop_i;
        idx[d]      = 0;
        lat[d]      = -1;
        lat_pend[d] = 1'b1;
      end
    end
  end

  // Downstream ready: always high, or the repeating 1,0,0,1 pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rp = rp + 1;
      if (ready_mode == 0) ready = 1'b1;
      else ready = ((rp % 4) == 0) || ((rp % 4) == 3);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_cmd(input logic [7:0] b, input logic [8:0] l, input logic lp);
    base = b;
    len = l;
    loop_i = lp;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    loop_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((busy[0] || busy[1] || active[0] || active[1]) && k < budget) begin
      tick(1);
      k++;
    end
    chk("done_within_budget", 32'(k < budget), 1);
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      logn[d] = 0;
      rn[d] = 0;
    end
  endtask

  task automatic chk_idle_zero(input string name);
    for (int d = 0; d < 2; d++)
      chk(name, 32'({raddr[d], mdata[d], mlast[d], mvalid[d], busy[d]}), 0);
  endtask

  initial begin
    int saved [2];
    for (int a = 0; a < 256; a++) rom[a] = 8'hFF - 8'(a);
    for (int d = 0; d < 2; d++) begin
      active[d] = 1'b0; lat_pend[d] = 1'b0; held[d] = 1'b0; logn[d] = 0; rn[d] = 0;
    end
    rst = 1'b1; start = 1'b0; loop_i = 1'b0; abort = 1'b0; ready = 1'b1;
    base = 8'h00; len = 9'd0;
    tick(3);
    chk_idle_zero("reset_outputs");
    rst = 1'b0;
    tick(1);

    // Basic 4-word read, back-to-back output.
    clear_logs();
    start_cmd(8'h00, 9'd4, 1'b0);
    wait_done(200);
    for (int d = 0; d < 2; d++) begin
      chk("s1_count", logn[d], 4);
      for (int i = 0; i < 4; i++)
        chk("s1_word", 32'(logw[d][i]), 32'({(i == 3), S1_DATA[i]}));
      chk("s1_back_to_back", logc[d][3] - logc[d][0], 3);
      chk("s1_busy_dropped", 32'(busy[d]), 0);
    end

    // Address wrap at the top of the ROM.
    clear_logs();
    rec_on = 1'b1;
    start_cmd(8'hFE, 9'd4, 1'b0);
    wait_done(200);
    rec_on = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("s2_count", logn[d], 4);
      chk("s2_addr_count", rn[d], 4);
      for (int i = 0; i < 4; i++) begin
        chk("s2_word", 32'(logw[d][i]), 32'({(i == 3), S2_DATA[i]}));
        chk("s2_raddr", 32'(rseq[d][i]), 32'(S2_ADDR[i]));
      end
    end

    // Backpressure 1,0,0,1.
    clear_logs();
    ready_mode = 1;
    start_cmd(8'h10, 9'd8, 1'b0);
    wait_done(400);
    ready_mode = 0;
    tick(1);
    for (int d = 0; d < 2; d++) begin
      chk("s3_count", logn[d], 8);
      for (int i = 0; i < 8; i++)
        chk("s3_word", 32'(logw[d][i]), 32'({(i == 7), 8'hEF - 8'(i)}));
    end

    // Looping playback, then abort mid-stream.
    clear_logs();
    start_cmd(8'h20, 9'd3, 1'b1);
    tick(13);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("abort_valid_low", 32'(mvalid[d]), 0);
      chk("abort_busy_low", 32'(busy[d]), 0);
      saved[d] = logn[d];
    end
    tick(8);
    for (int d = 0; d < 2; d++) begin
      chk("abort_no_more_words", logn[d], saved[d]);
      for (int i = 0; i < 6; i++)
        chk("s5_word", 32'(logw[d][i]), 32'({(i % 3 == 2), S5_DATA[i % 3]}));
    end

    // Reset in the middle of a run.
    start_cmd(8'h40, 9'd10, 1'b0);
    tick(4);
    rst = 1'b1;
    tick(1);
    chk_idle_zero("rst_mid_run_outputs");
    rst = 1'b0;
    tick(5);

    // START while busy is ignored.
    clear_logs();
    start_cmd(8'h10, 9'd8, 1'b0);
    tick(2);
    start_cmd(8'h80, 9'd2, 1'b0);
    wait_done(200);
    tick(3);
    for (int d = 0; d < 2; d++) begin
      chk("busy_start_count", logn[d], 8);
      chk("busy_start_last_word", 32'(logw[d][7]), 32'({1'b1, 8'hE8}));
    end

    // Zero length is a no-op.
    clear_logs();
    start_cmd(8'h33, 9'd0, 1'b0);
    for (int d = 0; d < 2; d++) chk("len0_not_busy", 32'(busy[d]), 0);
    tick(6);
    for (int d = 0; d < 2; d++) chk("len0_no_words", logn[d], 0);

    // Full sweep of all 256 words.
    clear_logs();
    start_cmd(8'h00, 9'd256, 1'b0);
    wait_done(1000);
    for (int d = 0; d < 2; d++) begin
      chk("full_sweep_count", logn[d], 256);
      chk("full_sweep_first", 32'(logw[d][0]), 32'({1'b0, 8'hFF}));
      chk("full_sweep_last", 32'(logw[d][255]), 32'({1'b1, 8'h00}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
